// File: rtl/knight_rider_scanner.sv
// Knight Rider LED scanner: one lit LED sweeps up and down a bar,
// bouncing at each end, with a push-button selecting one of four speeds.
//
// Ports:
//   clk          - clock, all state updates on its rising edge
//   reset        - synchronous, active-high reset
//   pwm_enable   - brightness gate from the upstream brightness stage
//   change_speed - asynchronous push-button level, rising edge = next speed
//   led_out      - LED drive, bit i lights LED i
//   position     - index of the active LED
//   direction    - 0 = scanning up, 1 = scanning down
//
// Build option: define KNIGHT_RIDER_TRAIL_EN to add a dimmed trail LED
// at the previous position (25% of the active LED's duty).
module knight_rider_scanner #(
    parameter int CLK_FREQ = 12500,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_enable,
    input  logic                change_speed,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [3:0]          position,
    output logic                direction
);

    localparam int BASE_PERIOD = CLK_FREQ / 4;
    localparam int CNT_W       = $clog2(BASE_PERIOD);

    localparam logic [3:0] LAST_POS = 4'(NUM_LEDS - 1);

    typedef enum logic {
        SCAN_UP   = 1'b0,
        SCAN_DOWN = 1'b1
    } state_t;

    // ------------------------------------------------------------
    // Push-button: two sync stages, then two edge-detect stages.
    // Stage 0 is the newest sample, stage 3 the oldest.
    // ------------------------------------------------------------
    logic [3:0] speed_sr;
    logic       speed_pulse;
    logic [1:0] speed_sel;

    // Rising edge: newer detect stage high, older one still low.
    assign speed_pulse = speed_sr[2] && !speed_sr[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_sr  <= '0;
            speed_sel <= 2'd0;
        end else begin
            speed_sr <= {speed_sr[2:0], change_speed};
            if (speed_pulse) begin
                speed_sel <= speed_sel + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------
    // Step timer
    // ------------------------------------------------------------
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] term_cnt;
    logic             at_term;
    logic             step_tick;

    always_comb begin
        term_cnt = CNT_W'(BASE_PERIOD - 1);
        unique case (speed_sel)
            2'd0: term_cnt = CNT_W'(BASE_PERIOD - 1);
            2'd1: term_cnt = CNT_W'(BASE_PERIOD / 2 - 1);
            2'd2: term_cnt = CNT_W'(BASE_PERIOD / 4 - 1);
            2'd3: term_cnt = CNT_W'(BASE_PERIOD / 8 - 1);
            default: term_cnt = CNT_W'(BASE_PERIOD - 1);
        endcase
    end

    assign at_term = (step_cnt == term_cnt);

    // A speed change restarts the period, so it also swallows the tick.
    assign step_tick = at_term && !speed_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (speed_pulse || at_term) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Direction FSM (state register / next-state / outputs)
    // ------------------------------------------------------------
    state_t     state;
    state_t     next_state;
    logic [3:0] next_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SCAN_UP;
            position <= 4'd0;
        end else begin
            state    <= next_state;
            position <= next_pos;
        end
    end

    // Turning at an end moves one LED back in the same step, so an
    // end LED is never held for two steps.
    always_comb begin
        next_state = state;
        next_pos   = position;
        if (step_tick) begin
            unique case (state)
                SCAN_UP: begin
                    if (position < LAST_POS) begin
                        next_pos = position + 4'd1;
                    end else begin
                        next_state = SCAN_DOWN;
                        next_pos   = position - 4'd1;
                    end
                end
                SCAN_DOWN: begin
                    if (position > 4'd0) begin
                        next_pos = position - 4'd1;
                    end else begin
                        next_state = SCAN_UP;
                        next_pos   = position + 4'd1;
                    end
                end
                default: begin
                    next_state = SCAN_UP;
                    next_pos   = 4'd0;
                end
            endcase
        end
    end

`ifdef KNIGHT_RIDER_TRAIL_EN
    logic [3:0] prev_pos;
    logic [1:0] trail_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pos  <= 4'd0;
            trail_cnt <= 2'd0;
        end else begin
            trail_cnt <= trail_cnt + 2'd1;
            if (step_tick) begin
                prev_pos <= position;
            end
        end
    end

    always_comb begin
        direction = (state == SCAN_DOWN);
        led_out   = '0;
        if (reset) begin
            led_out[0] = pwm_enable;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (position == 4'(i)) begin
                    led_out[i] = pwm_enable;
                end else if (prev_pos == 4'(i) &&
                             trail_cnt == 2'd0) begin
                    led_out[i] = pwm_enable;
                end
            end
        end
    end
`else
    always_comb begin
        direction = (state == SCAN_DOWN);
        led_out   = '0;
        if (reset) begin
            led_out[0] = pwm_enable;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (position == 4'(i)) begin
                    led_out[i] = pwm_enable;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Self-checking bench for knight_rider_scanner (CLK_FREQ=64, NUM_LEDS=8).
// Table-driven scan/bounce vectors plus hand sequences for speed/reset.
module tb_knight_rider_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_enable;
    logic       change_speed;
    logic [7:0] led_out;
    logic [3:0] position;
    logic       direction;

    knight_rider_scanner #(
        .CLK_FREQ(64),
        .NUM_LEDS(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_enable  (pwm_enable),
        .change_speed(change_speed),
        .led_out     (led_out),
        .position    (position),
        .direction   (direction)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] pos;
        logic       dir;
        logic [7:0] led;
    } exp_t;

    typedef struct {
        int         wait_cyc;
        logic       pwm;
        logic [3:0] pos;
        logic       dir;
        logic [7:0] led;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    int n_vec      = 0;
    int miscompares = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] pos,
                              input logic dir, input logic [7:0] led);
        exp_t e;
        e.name = name;
        e.pos  = pos;
        e.dir  = dir;
        e.led  = led;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        logic [7:0] got_led;
        n_vec++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: nothing expected");
            return;
        end
        e = sb.pop_front();
        got_led = led_out;
`ifdef KNIGHT_RIDER_TRAIL_EN
        got_led = got_led & (8'h01 << e.pos);
        e.led   = e.led & (8'h01 << e.pos);
`endif
        if (position !== e.pos || direction !== e.dir || got_led !== e.led) begin
            miscompares++;
            $display("FAIL %s: got pos=%0d dir=%0b led=%02h, want pos=%0d dir=%0b led=%02h",
                     e.name, position, direction, got_led, e.pos, e.dir, e.led);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] onehot(input logic p, input logic [3:0] pos);
        return p ? (8'h01 << pos) : 8'h00;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         ppos;
        logic       pdir;
        int         pos;
        logic       dir;
        logic       p;
        logic [3:0] cp_pos;
        bit         cp;

        reset        = 1'b1;
        pwm_enable   = 1'b1;
        change_speed = 1'b0;

        // Bounce table: 15 steps of period 16, checked just before
        // and just after each step.
        ppos = 0;
        pdir = 1'b0;
        for (int s = 1; s <= 15; s++) begin
            if (s <= 7) begin
                pos = s;
                dir = 1'b0;
            end else if (s <= 14) begin
                pos = 14 - s;
                dir = 1'b1;
            end else begin
                pos = s - 14;
                dir = 1'b0;
            end
            p = (s % 3 != 0);
            vt.push_back('{15, p, 4'(ppos), pdir, onehot(p, 4'(ppos))});
            vt.push_back('{1, p, 4'(pos), dir, onehot(p, 4'(pos))});
            ppos = pos;
            pdir = dir;
        end

        // Reset hold
        expect_out("reset_hold", 4'd0, 1'b0, 8'h01);
        tick(3);
        compare();
        reset = 1'b0;

        // Scan and bounce
        foreach (vt[i]) begin
            pwm_enable = vt[i].pwm;
            expect_out($sformatf("scan_%0d", i), vt[i].pos, vt[i].dir, vt[i].led);
            tick(vt[i].wait_cyc);
            compare();
        end

        // PWM gating at position 3
        pwm_enable = 1'b1;
        do_reset();
        expect_out("pwm_reach3", 4'd3, 1'b0, 8'h08);
        tick(48);
        compare();
        for (int i = 0; i < 8; i++) begin
            pwm_enable = (i % 2 == 1);
            expect_out($sformatf("pwm_toggle_%0d", i), 4'd3, 1'b0,
                       (i % 2 == 1) ? 8'h08 : 8'h00);
            tick(1);
            compare();
        end

        // Single press: speed 1 from the 4th edge, next step 8 later
        pwm_enable = 1'b1;
        do_reset();
        change_speed = 1'b1;
        expect_out("press_edge4", 4'd0, 1'b0, 8'h01);
        tick(4);
        compare();
        change_speed = 1'b0;
        expect_out("press_pre_step", 4'd0, 1'b0, 8'h01);
        tick(7);
        compare();
        expect_out("press_step1", 4'd1, 1'b0, 8'h02);
        tick(1);
        compare();
        expect_out("press_pre_step2", 4'd1, 1'b0, 8'h02);
        tick(7);
        compare();
        expect_out("press_step2", 4'd2, 1'b0, 8'h04);
        tick(1);
        compare();

        // Four presses: speed wraps back to 0; presses 2..4 land on
        // terminal counts and must swallow those steps.
        do_reset();
        for (int e = 1; e <= 44; e++) begin
            change_speed = (e <= 32) && (((e - 1) % 8) < 4);
            cp = 1'b1;
            cp_pos = 4'd0;
            case (e)
                4, 11, 12, 15: cp_pos = 4'd0;
                16, 19, 20:    cp_pos = 4'd1;
                22:            cp_pos = 4'd2;
                26, 28, 43:    cp_pos = 4'd4;
                44:            cp_pos = 4'd5;
                default:       cp = 1'b0;
            endcase
            if (cp) expect_out($sformatf("wrap_e%0d", e), cp_pos, 1'b0,
                               8'h01 << cp_pos);
            tick(1);
            if (cp) compare();
        end
        change_speed = 1'b0;

        // Reset overrides a coincident step
        do_reset();
        tick(15);
        reset = 1'b1;
        expect_out("reset_vs_tick", 4'd0, 1'b0, 8'h01);
        tick(1);
        compare();
        reset = 1'b0;

        // Reset while scanning down: led forced before the edge
        tick(1);
        do_reset();
        expect_out("down_pos6", 4'd6, 1'b1, 8'h40);
        tick(128);
        compare();
        reset = 1'b1;
        #1;
        n_vec++;
        if (led_out !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_led_comb: got led=%02h, want led=01", led_out);
        end
        expect_out("reset_from_down", 4'd0, 1'b0, 8'h01);
        tick(1);
        compare();
        reset = 1'b0;

`ifdef KNIGHT_RIDER_TRAIL_EN
        begin
            int ones;
            do_reset();
            n_vec++;
            if (led_out !== 8'h01) begin
                miscompares++;
                $display("FAIL trail_after_reset: got led=%02h, want 01", led_out);
            end
            tick(48);
            ones = 0;
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (led_out[3] !== 1'b1 || (led_out & 8'hF3) !== 8'h00) begin
                    miscompares++;
                    $display("FAIL trail_cycle_%0d: got led=%02h, want 08 or 0C",
                             i, led_out);
                end
                if (led_out[2] === 1'b1) ones++;
                tick(1);
            end
            n_vec++;
            if (ones != 2) begin
                miscompares++;
                $display("FAIL trail_duty: got %0d of 8, want 2 of 8", ones);
            end
        end
`endif

        n_vec++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: got %0d entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
